// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes, and signs are fixed up in FIN.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rh;       // partial product high half, or partial remainder
  logic [WIDTH-1:0] rl;       // multiplier bits, or dividend bits becoming quotient
  logic [WIDTH-1:0] operand;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_lat;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    neg_a     = ((op == OP_MULT) || (op == OP_DIV)) && a[WIDTH-1];
    neg_b     = ((op == OP_MULT) || (op == OP_DIV)) && b[WIDTH-1];
    mag_a     = neg_a ? -a : a;
    mag_b     = neg_b ? -b : b;

    mul_sum   = rl[0] ? ({1'b0, rh} + {1'b0, operand}) : {1'b0, rh};
    div_shift = {rh, rl[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, operand};
    div_sub   = div_shift[WIDTH-1:0] - operand;

    prod_fix  = neg_q ? -{rh, rl} : {rh, rl};
    fin_hi    = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo    = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fin_hi = a_lat;
        fin_lo = '1;
      end else begin
        fin_hi = neg_r ? -rh : rh;
        fin_lo = neg_q ? -rl : rl;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears the
  // whole datapath as well so nothing downstream can ever observe X.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      rh       <= '0;
      rl       <= '0;
      operand  <= '0;
      a_lat    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (clk_enable) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            OP_MTHI: begin
              hi   <= a;
              done <= 1'b1;
            end
            OP_MTLO: begin
              lo   <= a;
              done <= 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              state   <= MUL;
              busy    <= 1'b1;
              cnt     <= CNT_W'(WIDTH);
              rh      <= '0;
              rl      <= mag_b;
              operand <= mag_a;
              is_div  <= 1'b0;
              neg_q   <= neg_a ^ neg_b;
            end
            OP_DIV, OP_DIVU: begin
              state    <= DIV;
              busy     <= 1'b1;
              cnt      <= CNT_W'(WIDTH);
              rh       <= '0;
              rl       <= mag_a;
              operand  <= mag_b;
              a_lat    <= a;
              is_div   <= 1'b1;
              neg_q    <= neg_a ^ neg_b;
              neg_r    <= neg_a;
              div_zero <= (b == '0);
            end
            default: ;
          endcase
        end
        MUL: begin
          rh  <= mul_sum[WIDTH:1];
          rl  <= {mul_sum[0], rl[WIDTH-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIN;
        end
        DIV: begin
          rh  <= div_ge ? div_sub : div_shift[WIDTH-1:0];
          rl  <= {rl[WIDTH-2:0], div_ge};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIN;
        end
        FIN: begin
          hi    <= fin_hi;
          lo    <= fin_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed vector table, multi-cycle corner
// sequences and random operations against an arithmetic reference model of HI/LO.
module tb_mips_cpu_muldiv;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_cmp;
  int          n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(clk_enable),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one accepted request, from plain integer arithmetic.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin
        p = 64'(sx * sy);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        p = 64'(x) * 64'(y);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2, 3'd3: begin
        if (y == 0) begin
          m_hi = x;
          m_lo = 32'hffff_ffff;
        end else if (o == 3'd2) begin
          q = sx / sy;
          r = sx % sy;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one request, scramble the operand inputs, then wait (bounded) for done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    model_apply(o, x, y);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o);
    return (o == 3'd4 || o == 3'd5) ? 0 : 33;
  endfunction

  initial begin
    int lat;
    int bcnt;

    vecs = '{
      '{3'd1, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001},
      '{3'd0, 32'hffff_fffd, 32'h0000_0007, 32'hffff_ffff, 32'hffff_ffeb},
      '{3'd2, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 32'hffff_fffd},
      '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hffff_ffff},
      '{3'd2, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 32'h8000_0000},
      '{3'd2, 32'h0000_0007, 32'hffff_fffe, 32'h0000_0001, 32'hffff_fffd},
      '{3'd2, 32'hffff_fff0, 32'h0000_0000, 32'hffff_fff0, 32'hffff_ffff},
      '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{3'd4, 32'hdead_beef, 32'h0000_0000, 32'hdead_beef, 32'h0000_0000},
      '{3'd5, 32'h0bad_f00d, 32'h0000_0000, 32'hdead_beef, 32'h0bad_f00d},
      '{3'd3, 32'hffff_ffff, 32'h0000_0010, 32'h0000_000f, 32'h0fff_ffff},
      '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000},
      '{3'd0, 32'hffff_ffff, 32'h0000_0001, 32'hffff_ffff, 32'hffff_ffff}
    };

    n_cmp = 0;
    n_fail = 0;
    clk = 1'b0;
    reset = 1'b1;
    clk_enable = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    step();
    step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;

    // Reserved op codes start nothing and produce no done.
    for (int k = 6; k <= 7; k++) begin
      op = 3'(k);
      a = 32'h1234_5678;
      start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("ignored_op%0d_done", k), done, 0);
      check($sformatf("ignored_op%0d_busy", k), busy, 0);
      step();
      check($sformatf("ignored_op%0d_hilo", k), {hi, lo}, 64'h0);
    end

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op));
      check($sformatf("vec%0d_busy_cycles", i), bcnt, exp_lat(vecs[i].op));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d_no_x", i), $isunknown({hi, lo, busy, done}), 0);
    end

    // MULT followed by MTLO issued in the done cycle.
    op = 3'd0;
    a = 32'hffff_fffd;
    b = 32'h0000_0007;
    start = 1'b1;
    step();
    start = 1'b0;
    model_apply(3'd0, 32'hffff_fffd, 32'h0000_0007);
    lat = 0;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    check("b2b_mult_latency", lat, 33);
    check("b2b_mult_hi", hi, 32'hffff_ffff);
    check("b2b_mult_lo", lo, 32'hffff_ffeb);
    op = 3'd5;
    a = 32'h1234_5678;
    start = 1'b1;
    step();
    start = 1'b0;
    model_apply(3'd5, 32'h1234_5678, 32'h0);
    check("b2b_mtlo_lo", lo, 32'h1234_5678);
    check("b2b_mtlo_hi", hi, 32'hffff_ffff);
    check("b2b_mtlo_busy", busy, 0);
    check("b2b_mtlo_done", done, 1);
    step();
    check("b2b_done_pulse_end", done, 0);

    // MULTU with a 5-cycle clock-enable stall and an ignored start while busy.
    op = 3'd1;
    a = 32'h0001_2345;
    b = 32'h0000_6789;
    start = 1'b1;
    step();
    start = 1'b0;
    model_apply(3'd1, 32'h0001_2345, 32'h0000_6789);
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        op = 3'd3;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
      end
      if (lat == 6) start = 1'b0;
      if (lat == 10) clk_enable = 1'b0;
      if (lat == 15) clk_enable = 1'b1;
      step();
      lat++;
    end
    check("stall_latency", lat, 38);
    check("stall_hi", hi, m_hi);
    check("stall_lo", lo, m_lo);
    clk_enable = 1'b0;
    step();
    step();
    check("stall_done_held", done, 1);
    clk_enable = 1'b1;
    step();
    check("stall_done_once", done, 0);
    check("stall_no_second_op", busy, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'h0;
        1: y = 32'hffff_ffff;
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(o, x, y, lat, bcnt);
      check($sformatf("rand%0d_latency", i), lat, exp_lat(o));
      check($sformatf("rand%0d_hi", i), hi, m_hi);
      check($sformatf("rand%0d_lo", i), lo, m_lo);
    end

    // Reset in the middle of a DIVU.
    do_op(3'd4, 32'haaaa_aaaa, 32'h0, lat, bcnt);
    do_op(3'd5, 32'haaaa_aaaa, 32'h0, lat, bcnt);
    op = 3'd3;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    check("abort_hi_retained", hi, 32'haaaa_aaaa);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    do_op(3'd1, 32'd3, 32'd5, lat, bcnt);
    check("post_abort_latency", lat, 33);
    check("post_abort_hi", hi, 0);
    check("post_abort_lo", lo, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
